// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM state encoding, frame line levels
// and the parity helper used when building frames.
package uart_pkg;

    // Transmit FSM states; PARITY is only entered when parity is compiled in.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    // Line levels for the framing bits; the idle line sits at STOP_BIT.
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Parity over the data bits; odd=1 selects odd parity.
    // Callers zero-extend their data, which leaves the XOR reduction unchanged.
    function automatic logic parity_bit(input logic [63:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_buffer.sv
// Synchronous TX byte buffer: filled by the host, drained by the serializer.
// Pointers wrap modulo depth; count is one bit wider than the pointers so
// full and empty are distinguishable. Flags are registered from the next count.
// Overflow is sticky until reset and records a write dropped while full.
module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 wr_en,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 empty,
    output logic                 full,
    output logic                 overflow
);

    localparam int DEPTH = 1 << FIFO_WIDTH;
    localparam logic [FIFO_WIDTH:0] COUNT_FULL = (FIFO_WIDTH + 1)'(DEPTH);
    localparam logic [FIFO_WIDTH:0] COUNT_ONE  = (FIFO_WIDTH + 1)'(1);

    logic [DATA_BITS-1:0]  mem [DEPTH];
    logic [FIFO_WIDTH-1:0] wr_ptr;
    logic [FIFO_WIDTH-1:0] rd_ptr;
    logic [FIFO_WIDTH:0]   count;
    logic [FIFO_WIDTH:0]   count_next;
    logic                  do_wr;
    logic                  do_rd;

    assign rd_data = mem[rd_ptr];

    // Accept/pop decisions; a pop in the same cycle frees a slot for a write when full.
    always_comb begin
        do_rd      = rd_en && (count != '0);
        do_wr      = wr_en && ((count != COUNT_FULL) || do_rd);
        count_next = count;
        if (do_wr && !do_rd) begin
            count_next = count + COUNT_ONE;
        end else if (!do_wr && do_rd) begin
            count_next = count - COUNT_ONE;
        end
    end

    // Pointer, count and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count    <= count_next;
            empty    <= (count_next == '0);
            full     <= (count_next == COUNT_FULL);
            overflow <= overflow | (wr_en && !do_wr);
        end
    end

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit path: host bytes go into uart_tx_buffer and are serialized
// LSB-first as start/data/[parity]/stop frames, CLKS_PER_BIT clocks per bit.
// Define UART_TX_PARITY_EN to insert a parity bit after the data bits.
// All outputs are registered. tx_state exposes the FSM state for observation.
//
// Handshake: Load_Data is a one-cycle strobe qualified by !BIST_Mode; there is
// no ready - a strobe while the buffer is full (and no pop that cycle) is
// dropped and latches FIFO_Overflow.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int FIFO_WIDTH   = 2,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] Tx_Data,
    input  logic                 Load_Data,
    input  logic                 BIST_Mode,
    output logic                 Tx_Out,
    output logic                 Tx_Busy,
    output logic                 FIFO_Empty,
    output logic                 FIFO_Full,
    output logic                 FIFO_Overflow,
    output tx_state_t            tx_state
);

    localparam int TW    = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0]    TIMER_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0]    TIMER_ONE  = TW'(1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
    localparam logic             ODD        = (PARITY_ODD != 0);

`ifdef UART_TX_PARITY_EN
    localparam tx_state_t AFTER_DATA = PARITY;
`else
    localparam tx_state_t AFTER_DATA = STOP;
`endif

    tx_state_t            state;
    tx_state_t            state_next;
    logic [TW-1:0]        timer;
    logic [TW-1:0]        timer_next;
    logic [IDX_W-1:0]     bit_idx;
    logic [IDX_W-1:0]     bit_idx_next;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] shift_next;
    logic                 par;
    logic                 par_next;
    logic                 tx_out_next;
    logic                 busy_next;
    logic                 pop;
    logic                 can_pop;
    logic                 bit_last;
    logic [DATA_BITS-1:0] rd_data;
    logic                 buf_empty;

    uart_tx_buffer #(
        .DATA_BITS (DATA_BITS),
        .FIFO_WIDTH(FIFO_WIDTH)
    ) u_buffer (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_data (Tx_Data),
        .wr_en   (Load_Data && !BIST_Mode),
        .rd_en   (pop),
        .rd_data (rd_data),
        .empty   (buf_empty),
        .full    (FIFO_Full),
        .overflow(FIFO_Overflow)
    );

    assign FIFO_Empty = buf_empty;
    assign tx_state   = state;

    // Next-state, bit timing and shift control; the line level is decoded from the next state.
    always_comb begin
        state_next   = state;
        timer_next   = timer;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        par_next     = par;
        pop          = 1'b0;
        can_pop      = !buf_empty && !BIST_Mode;
        bit_last     = (timer == TIMER_LAST);

        case (state)
            IDLE: begin
                if (can_pop) begin
                    pop        = 1'b1;
                    state_next = START;
                    timer_next = '0;
                    shift_next = rd_data;
                    par_next   = parity_bit(64'(rd_data), ODD);
                end
            end
            START: begin
                if (bit_last) begin
                    state_next   = DATA;
                    timer_next   = '0;
                    bit_idx_next = '0;
                end else begin
                    timer_next = timer + TIMER_ONE;
                end
            end
            DATA: begin
                if (bit_last) begin
                    timer_next = '0;
                    if (bit_idx == IDX_LAST) begin
                        state_next = AFTER_DATA;
                    end else begin
                        bit_idx_next = bit_idx + IDX_ONE;
                        shift_next   = shift >> 1;
                    end
                end else begin
                    timer_next = timer + TIMER_ONE;
                end
            end
            PARITY: begin
                if (bit_last) begin
                    state_next = STOP;
                    timer_next = '0;
                end else begin
                    timer_next = timer + TIMER_ONE;
                end
            end
            STOP: begin
                if (bit_last) begin
                    timer_next = '0;
                    // Back-to-back frames: the next start bit follows the stop bit directly.
                    if (can_pop) begin
                        pop        = 1'b1;
                        state_next = START;
                        shift_next = rd_data;
                        par_next   = parity_bit(64'(rd_data), ODD);
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    timer_next = timer + TIMER_ONE;
                end
            end
            default: begin
                state_next = IDLE;
                timer_next = '0;
            end
        endcase

        case (state_next)
            START:   tx_out_next = START_BIT;
            DATA:    tx_out_next = shift_next[0];
            PARITY:  tx_out_next = par_next;
            default: tx_out_next = STOP_BIT;
        endcase
        busy_next = (state_next != IDLE);
    end

    // FSM, timer, shift register and registered line outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shift   <= '0;
            par     <= 1'b0;
            Tx_Out  <= STOP_BIT;
            Tx_Busy <= 1'b0;
        end else begin
            state   <= state_next;
            timer   <= timer_next;
            bit_idx <= bit_idx_next;
            shift   <= shift_next;
            par     <= par_next;
            Tx_Out  <= tx_out_next;
            Tx_Busy <= busy_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer (CLKS_PER_BIT=4, DATA_BITS=8, FIFO_WIDTH=2).
// Bytes expected on the line are queued when loaded; a line monitor captures
// every frame clock by clock and compares it against the queued byte's frame.
module tb_uart_tx_serializer;
    import uart_pkg::*;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME_CLKS = NBITS * CPB;
    localparam logic PODD = 1'b0;

    logic       clk;
    logic       rst_n;
    logic [7:0] Tx_Data;
    logic       Load_Data;
    logic       BIST_Mode;
    logic       Tx_Out;
    logic       Tx_Busy;
    logic       FIFO_Empty;
    logic       FIFO_Full;
    logic       FIFO_Overflow;
    tx_state_t  tx_state;

    logic [7:0] exp_q[$];
    int         start_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;

    uart_tx_serializer #(
        .DATA_BITS   (8),
        .FIFO_WIDTH  (2),
        .CLKS_PER_BIT(CPB),
        .PARITY_ODD  (0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .Tx_Data      (Tx_Data),
        .Load_Data    (Load_Data),
        .BIST_Mode    (BIST_Mode),
        .Tx_Out       (Tx_Out),
        .Tx_Busy      (Tx_Busy),
        .FIFO_Empty   (FIFO_Empty),
        .FIFO_Full    (FIFO_Full),
        .FIFO_Overflow(FIFO_Overflow),
        .tx_state     (tx_state)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Per-clock line waveform of one frame: start, data LSB first, [parity], stop.
    function automatic logic [63:0] frame_of(input logic [7:0] b);
        logic [63:0] f;
        logic [15:0] bits;
        f = '0;
        bits = '0;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i + 1] = b[i];
`ifdef UART_TX_PARITY_EN
        bits[9] = (^b) ^ PODD;
`endif
        bits[NBITS - 1] = 1'b1;
        for (int k = 0; k < NBITS; k++)
            for (int c = 0; c < CPB; c++) f[k * CPB + c] = bits[k];
        return f;
    endfunction

    // Driver tasks; each call holds its values for one clock.
    task automatic drive_load(input logic [7:0] b);
        Tx_Data   = b;
        Load_Data = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_busy(input int budget);
        int n;
        n = 0;
        while (!Tx_Busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_busy_timeout", 64'(n >= budget), 64'(0));
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || Tx_Busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 64'(n >= budget), 64'(0));
    endtask

    // Line monitor: captures each frame per clock and scores it against exp_q.
    initial begin
        logic [63:0] cap;
        logic [7:0]  b;
        bit          aborted;
        forever begin
            @(negedge clk);
            if (rst_n && Tx_Out == 1'b0) begin
                start_q.push_back(cyc);
                cap = '0;
                aborted = 1'b0;
                for (int i = 0; i < FRAME_CLKS; i++) begin
                    if (i > 0) @(negedge clk);
                    if (!rst_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    cap[i] = Tx_Out;
                end
                if (!aborted) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: got %0h expected no frame", cap);
                    end else begin
                        b = exp_q.pop_front();
                        check("frame", cap, frame_of(b));
                    end
                end
            end
        end
    end

    // Stimulus
    initial begin
        int n;
        int busy_clks;
        rst_n     = 1'b0;
        Tx_Data   = 8'h00;
        Load_Data = 1'b0;
        BIST_Mode = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_tx_out", 64'(Tx_Out), 64'(1));
        check("rst_busy", 64'(Tx_Busy), 64'(0));
        check("rst_empty", 64'(FIFO_Empty), 64'(1));
        check("rst_full", 64'(FIFO_Full), 64'(0));
        check("rst_overflow", 64'(FIFO_Overflow), 64'(0));
        check("rst_state", 64'(tx_state), 64'(IDLE));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: single byte 0xA5, latency and busy length
        exp_q.push_back(8'hA5);
        drive_load(8'hA5);
        Load_Data = 1'b0;
        check("t1_line_before_pop", 64'(Tx_Out), 64'(1));
        check("t1_empty_after_load", 64'(FIFO_Empty), 64'(0));
        @(negedge clk);
        check("t1_start_latency", 64'(Tx_Out), 64'(0));
        check("t1_busy_at_start", 64'(Tx_Busy), 64'(1));
        busy_clks = 0;
        while (Tx_Busy && busy_clks < 200) begin
            busy_clks++;
            @(negedge clk);
        end
`ifdef UART_TX_PARITY_EN
        check("t1_busy_clks", 64'(busy_clks), 64'(44));
`else
        check("t1_busy_clks", 64'(busy_clks), 64'(40));
`endif
        check("t1_empty_after", 64'(FIFO_Empty), 64'(1));
        wait_drain(100);
        repeat (3) @(negedge clk);

        // 2: back-to-back frames, no idle gap
        start_q.delete();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        drive_load(8'h00);
        drive_load(8'hFF);
        Load_Data = 1'b0;
        wait_drain(300);
        check("t2_frame_count", 64'(start_q.size()), 64'(2));
        if (start_q.size() == 2)
            check("t2_no_gap", 64'(start_q[1] - start_q[0]), 64'(FRAME_CLKS));
        repeat (3) @(negedge clk);

        // 3: six loads, fifth fills the buffer, sixth is dropped
        start_q.delete();
        for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i * 8'h11));
        for (int i = 1; i <= 6; i++) drive_load(8'(i * 8'h11));
        Load_Data = 1'b0;
        check("t3_full", 64'(FIFO_Full), 64'(1));
        check("t3_overflow", 64'(FIFO_Overflow), 64'(1));
        wait_drain(800);
        check("t3_frames_sent", 64'(start_q.size()), 64'(5));
        check("t3_overflow_sticky", 64'(FIFO_Overflow), 64'(1));
        check("t3_full_after", 64'(FIFO_Full), 64'(0));

        // Clear sticky overflow
        rst_n = 1'b0;
        @(negedge clk);
        check("t3_overflow_cleared", 64'(FIFO_Overflow), 64'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 4: reset during data bit 3 of 0x3C with 0x5A queued behind it
        start_q.delete();
        drive_load(8'h3C);
        drive_load(8'h5A);
        Load_Data = 1'b0;
        wait_busy(20);
        repeat (17) @(negedge clk);
        check("t4_in_data", 64'(tx_state), 64'(DATA));
        rst_n = 1'b0;
        #1;
        check("t4_async_tx_out", 64'(Tx_Out), 64'(1));
        check("t4_async_busy", 64'(Tx_Busy), 64'(0));
        check("t4_async_empty", 64'(FIFO_Empty), 64'(1));
        check("t4_async_full", 64'(FIFO_Full), 64'(0));
        check("t4_async_overflow", 64'(FIFO_Overflow), 64'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (60) begin
            @(negedge clk);
            if (Tx_Busy || !Tx_Out) n++;
        end
        check("t4_no_frame_after", 64'(n), 64'(0));
        check("t4_empty_after", 64'(FIFO_Empty), 64'(1));

        // 5: BIST freeze mid-frame with two bytes queued
        start_q.delete();
        exp_q.push_back(8'h81);
        drive_load(8'h81);
        drive_load(8'h42);
        drive_load(8'h24);
        Load_Data = 1'b0;
        wait_busy(20);
        repeat (8) @(negedge clk);
        BIST_Mode = 1'b1;
        drive_load(8'hEE);
        Load_Data = 1'b0;
        wait_drain(100);
        repeat (20) @(negedge clk);
        check("t5_hold_busy", 64'(Tx_Busy), 64'(0));
        check("t5_hold_line", 64'(Tx_Out), 64'(1));
        check("t5_hold_state", 64'(tx_state), 64'(IDLE));
        check("t5_buffer_kept", 64'(FIFO_Empty), 64'(0));
        check("t5_frames_frozen", 64'(start_q.size()), 64'(1));
        exp_q.push_back(8'h42);
        exp_q.push_back(8'h24);
        BIST_Mode = 1'b0;
        wait_drain(300);
        check("t5_frames_total", 64'(start_q.size()), 64'(3));
        check("t5_empty_after", 64'(FIFO_Empty), 64'(1));

`ifdef UART_TX_PARITY_EN
        // 6: even parity frames (0xA5 -> parity 0, 0x07 -> parity 1)
        check("t6_model_par_a5", 64'(frame_of(8'hA5)[36]), 64'(0));
        check("t6_model_par_07", 64'(frame_of(8'h07)[36]), 64'(1));
        exp_q.push_back(8'hA5);
        drive_load(8'hA5);
        Load_Data = 1'b0;
        wait_busy(20);
        busy_clks = 0;
        while (Tx_Busy && busy_clks < 200) begin
            busy_clks++;
            @(negedge clk);
        end
        check("t6_busy_clks", 64'(busy_clks), 64'(44));
        exp_q.push_back(8'h07);
        drive_load(8'h07);
        Load_Data = 1'b0;
        wait_drain(200);
`endif

        repeat (5) @(negedge clk);
        check("final_exp_q_empty", 64'(exp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
